// File: rtl/coef_regfile_mp.sv
// Multi-port coefficient register file.
// LANES independent write and read ports over a DEPTH x WIDTH array. Writes
// from several lanes to one address resolve to the highest-index lane. Reads
// are write-first, so a same-cycle write is visible at once. A clear
// sequence (started by reset or clear_i) zeroes LANES words per cycle.
module coef_regfile_mp #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 256,
    parameter int LANES      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [LANES-1:0]            we_i,
    input  logic [LANES*ADDR_WIDTH-1:0] waddr_i,
    input  logic [LANES*WIDTH-1:0]      din_i,
    input  logic                        re_i,
    input  logic [LANES*ADDR_WIDTH-1:0] raddr_i,
    output logic [LANES*WIDTH-1:0]      dout_o,
    output logic                        dout_valid_o,
    input  logic                        clear_i,
    output logic                        busy_o,
    output logic                        wcoll_o
);
    localparam int ROWS = DEPTH / LANES;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                            state;
    logic [RW-1:0]                     row;
    logic [WIDTH-1:0]                  mem [DEPTH];
    logic [LANES-1:0][ADDR_WIDTH-1:0]  waddr, raddr;
    logic [LANES-1:0][WIDTH-1:0]       din, rdata;
    logic                              wr_ok, rd_ok, coll;

    assign waddr  = waddr_i;
    assign raddr  = raddr_i;
    assign din    = din_i;
    assign busy_o = (state == CLEAR);

    // Accesses are only taken in IDLE; a clear request claims its own cycle.
    assign wr_ok = (state == IDLE) && !clear_i && !rst_i;
    assign rd_ok = wr_ok && re_i;

    function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // Storage: clear a block of LANES words, or apply lane writes in
    // ascending order so the highest lane lands last.
    always_ff @(posedge clk_i) begin
        if (state == CLEAR) begin
            for (int i = 0; i < LANES; i++)
                mem[ADDR_WIDTH'(int'(row) * LANES + i)] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < LANES; k++)
                if (we_i[k] && in_rng(waddr[k]))
                    mem[waddr[k]] <= din[k];
        end
    end

    // Per-lane read data, with forwarding from any same-cycle write.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < LANES; k++) begin
            if (in_rng(raddr[k])) begin
                rdata[k] = mem[raddr[k]];
                for (int j = 0; j < LANES; j++)
                    if (wr_ok && we_i[j] && waddr[j] == raddr[k])
                        rdata[k] = din[j];
            end
        end
    end

    // Detect two enabled lanes sharing a write address.
    always_comb begin
        coll = 1'b0;
        for (int j = 0; j < LANES; j++)
            for (int k = j + 1; k < LANES; k++)
                if (we_i[j] && we_i[k] && waddr[j] == waddr[k])
                    coll = 1'b1;
    end

    // Control FSM plus registered read data and status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= CLEAR;
            row          <= '0;
            dout_o       <= '0;
            dout_valid_o <= 1'b0;
            wcoll_o      <= 1'b0;
        end else begin
            dout_valid_o <= rd_ok;
            wcoll_o      <= wr_ok && coll;
            if (rd_ok)
                dout_o <= rdata;
            case (state)
                IDLE: begin
                    if (clear_i) begin
                        state <= CLEAR;
                        row   <= '0;
                    end
                end
                CLEAR: begin
                    if (row == RW'(ROWS - 1))
                        state <= IDLE;
                    else
                        row <= row + 1'b1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_coef_regfile_mp.sv
// Scoreboard bench for coef_regfile_mp: a reference memory predicts read data
// (with write-first forwarding) and collisions; expected reads are queued at
// issue and compared when dout_valid_o appears.
module tb_coef_regfile_mp;
    localparam int WIDTH = 12;
    localparam int DEPTH = 256;
    localparam int LANES = 16;
    localparam int AW    = 8;
    localparam int DW    = LANES * WIDTH;
    localparam int AWW   = LANES * AW;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [LANES-1:0] we_i = '0;
    logic [AWW-1:0]   waddr_i = '0;
    logic [DW-1:0]    din_i = '0;
    logic             re_i = 1'b0;
    logic [AWW-1:0]   raddr_i = '0;
    logic [DW-1:0]    dout_o;
    logic             dout_valid_o;
    logic             clear_i = 1'b0;
    logic             busy_o;
    logic             wcoll_o;

    coef_regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .we_i(we_i), .waddr_i(waddr_i), .din_i(din_i),
        .re_i(re_i), .raddr_i(raddr_i), .dout_o(dout_o), .dout_valid_o(dout_valid_o),
        .clear_i(clear_i), .busy_o(busy_o), .wcoll_o(wcoll_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_vec = 0;
    int            n_err = 0;
    logic [WIDTH-1:0] model [DEPTH];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] last_dout = '0;
    logic          exp_coll = 1'b0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Drive one IDLE-state cycle; predict read data and collision from the model.
    task automatic apply(input logic [LANES-1:0] we, input logic [AWW-1:0] wa,
                         input logic [DW-1:0] d, input logic re, input logic [AWW-1:0] ra);
        logic [DW-1:0] exp;
        logic [AW-1:0] a;
        exp = '0;
        exp_coll = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            a = ra[k*AW +: AW];
            exp[k*WIDTH +: WIDTH] = model[a];
            for (int j = 0; j < LANES; j++)
                if (we[j] && wa[j*AW +: AW] == a) exp[k*WIDTH +: WIDTH] = d[j*WIDTH +: WIDTH];
        end
        for (int j = 0; j < LANES; j++)
            for (int k = j + 1; k < LANES; k++)
                if (we[j] && we[k] && wa[j*AW +: AW] == wa[k*AW +: AW]) exp_coll = 1'b1;
        for (int j = 0; j < LANES; j++)
            if (we[j]) model[wa[j*AW +: AW]] = d[j*WIDTH +: WIDTH];
        if (re) sb_q.push_back(exp);
        we_i = we; waddr_i = wa; din_i = d; re_i = re; raddr_i = ra;
        tick();
        we_i = '0; re_i = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        n_vec++; if (dout_o !== '0) begin n_err++; $display("FAIL rst_dout got=%h exp=0", dout_o); end
        n_vec++; if (dout_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", dout_valid_o); end
        n_vec++; if (wcoll_o !== 1'b0) begin n_err++; $display("FAIL rst_wcoll got=%b exp=0", wcoll_o); end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rst_busy got=%b exp=1", busy_o); end
        cnt = 0;
        while (busy_o === 1'b1 && cnt < 64) begin cnt++; tick(); end
        n_vec++; if (cnt != 16) begin n_err++; $display("FAIL rst_busy_len got=%0d exp=16", cnt); end
        model_zero();
        last_dout = '0;
    endtask

    // Read a set of addresses on all lanes and check against the scoreboard.
    task automatic test_read(input string nm, input logic [AWW-1:0] ra);
        logic [DW-1:0] exp;
        apply('0, '0, '0, 1'b1, ra);
        n_vec++; if (dout_valid_o !== 1'b1) begin n_err++; $display("FAIL %s_valid got=%b exp=1", nm, dout_valid_o); end
        n_vec++;
        if (sb_q.size() == 0) begin n_err++; $display("FAIL %s_sb empty queue", nm); end
        else begin
            exp = sb_q.pop_front();
            if (dout_o !== exp) begin n_err++; $display("FAIL %s_data got=%h exp=%h", nm, dout_o, exp); end
            last_dout = exp;
        end
    endtask

    task automatic test_write_lanes();
        logic [AWW-1:0] wa;
        logic [DW-1:0]  d;
        for (int k = 0; k < LANES; k++) begin
            wa[k*AW +: AW]    = AW'(16 * k + 3);
            d[k*WIDTH +: WIDTH] = WIDTH'(12'h100 + k);
        end
        apply('1, wa, d, 1'b0, '0);
        n_vec++; if (wcoll_o !== 1'b0) begin n_err++; $display("FAIL wlanes_wcoll got=%b exp=0", wcoll_o); end
        n_vec++; if (dout_valid_o !== 1'b0) begin n_err++; $display("FAIL wlanes_valid got=%b exp=0", dout_valid_o); end
        n_vec++; if (dout_o !== last_dout) begin n_err++; $display("FAIL wlanes_hold got=%h exp=%h", dout_o, last_dout); end
        test_read("wlanes", wa);
    endtask

    task automatic test_collision();
        logic [AWW-1:0] wa;
        logic [DW-1:0]  d;
        wa = '0; d = '0;
        wa[0 +: AW] = 8'd5;              d[0 +: WIDTH] = 12'hAAA;
        wa[15*AW +: AW] = 8'd5;          d[15*WIDTH +: WIDTH] = 12'h555;
        apply(16'h8001, wa, d, 1'b0, '0);
        n_vec++; if (wcoll_o !== exp_coll || exp_coll !== 1'b1) begin n_err++; $display("FAIL coll_pulse got=%b exp=1", wcoll_o); end
        apply('0, '0, '0, 1'b0, '0);
        n_vec++; if (wcoll_o !== 1'b0) begin n_err++; $display("FAIL coll_clear got=%b exp=0", wcoll_o); end
        test_read("coll", {LANES{8'd5}});
    endtask

    task automatic test_forward();
        logic [AWW-1:0] wa;
        logic [DW-1:0]  d;
        logic [DW-1:0]  exp;
        wa = '0; d = '0;
        wa[2*AW +: AW] = 8'd9; d[2*WIDTH +: WIDTH] = 12'h7FF;
        apply(16'h0004, wa, d, 1'b1, {LANES{8'd9}});
        n_vec++; if (dout_valid_o !== 1'b1) begin n_err++; $display("FAIL fwd_valid got=%b exp=1", dout_valid_o); end
        n_vec++;
        if (sb_q.size() == 0) begin n_err++; $display("FAIL fwd_sb empty queue"); end
        else begin
            exp = sb_q.pop_front();
            if (dout_o !== exp) begin n_err++; $display("FAIL fwd_data got=%h exp=%h", dout_o, exp); end
            last_dout = exp;
        end
    endtask

    task automatic test_random();
        logic [LANES-1:0] we;
        logic [AWW-1:0]   wa, ra;
        logic [DW-1:0]    d, exp;
        logic             re;
        for (int c = 0; c < 24; c++) begin
            we = LANES'($urandom);
            re = 1'($urandom);
            for (int k = 0; k < LANES; k++) begin
                wa[k*AW +: AW] = AW'($urandom_range(0, 7));
                ra[k*AW +: AW] = AW'($urandom_range(0, 7));
                d[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
            apply(we, wa, d, re, ra);
            n_vec++; if (wcoll_o !== exp_coll) begin n_err++; $display("FAIL rnd_wcoll c=%0d got=%b exp=%b", c, wcoll_o, exp_coll); end
            n_vec++; if (dout_valid_o !== re) begin n_err++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, dout_valid_o, re); end
            if (re) begin
                n_vec++;
                if (sb_q.size() == 0) begin n_err++; $display("FAIL rnd_sb empty queue"); end
                else begin
                    exp = sb_q.pop_front();
                    if (dout_o !== exp) begin n_err++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, dout_o, exp); end
                    last_dout = exp;
                end
            end else begin
                n_vec++; if (dout_o !== last_dout) begin n_err++; $display("FAIL rnd_hold c=%0d got=%h exp=%h", c, dout_o, last_dout); end
            end
        end
    endtask

    // Drive writes and reads on every clear cycle; count busy cycles up to limit.
    task automatic clear_cycles(input string nm, input int limit, output int cnt);
        logic [AWW-1:0] wa;
        for (int k = 0; k < LANES; k++) wa[k*AW +: AW] = AW'(16 * k + 3);
        cnt = 0;
        while (busy_o === 1'b1 && cnt < limit) begin
            cnt++;
            we_i = '1; waddr_i = wa; din_i = {LANES{12'h0AB}}; re_i = 1'b1; raddr_i = wa;
            tick();
            n_vec++; if (dout_valid_o !== 1'b0) begin n_err++; $display("FAIL %s_valid cyc=%0d got=%b exp=0", nm, cnt, dout_valid_o); end
        end
        we_i = '0; re_i = 1'b0;
    endtask

    task automatic test_clear();
        logic [AWW-1:0] wa;
        int cnt;
        for (int k = 0; k < LANES; k++) wa[k*AW +: AW] = AW'(16 * k + 3);
        // clear with full-width writes in the accept cycle
        clear_i = 1'b1; we_i = '1; waddr_i = wa; din_i = {LANES{12'h3C3}}; re_i = 1'b1; raddr_i = wa;
        tick();
        clear_i = 1'b0; we_i = '0; re_i = 1'b0;
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL clr_busy got=%b exp=1", busy_o); end
        n_vec++; if (dout_valid_o !== 1'b0) begin n_err++; $display("FAIL clr_accept_valid got=%b exp=0", dout_valid_o); end
        clear_cycles("clr", 64, cnt);
        n_vec++; if (cnt != 16) begin n_err++; $display("FAIL clr_len got=%0d exp=16", cnt); end
        n_vec++; if (dout_o !== last_dout) begin n_err++; $display("FAIL clr_hold got=%h exp=%h", dout_o, last_dout); end
        model_zero();
        test_read("clr_rd", wa);
        // second clear, reset pulsed on clear cycle 8
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        clear_cycles("clr2", 7, cnt);
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL clr2_busy8 got=%b exp=1", busy_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        last_dout = '0;
        n_vec++; if (dout_o !== '0) begin n_err++; $display("FAIL clr2_rst_dout got=%h exp=0", dout_o); end
        clear_cycles("clr3", 64, cnt);
        n_vec++; if (cnt != 16) begin n_err++; $display("FAIL clr_restart_len got=%0d exp=16", cnt); end
        model_zero();
        test_read("post_clr_a", wa);
        test_read("post_clr_b", {8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9, 8'd8,
                                 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_zero();
        test_reset();
        test_read("rd0", {8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9, 8'd8,
                          8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
        test_write_lanes();
        test_collision();
        test_forward();
        test_random();
        test_clear();
        n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
